// File: rtl/lcd_pkg.sv
// Shared types, default 800x480 panel timing and the power-on palette ramp
// for the LCD scan-out engine.
package lcd_pkg;

   typedef struct packed {
      logic [7:0] r;
      logic [7:0] g;
      logic [7:0] b;
   } rgb_t;

   // Control tags travelling alongside a pixel fetch.
   typedef struct packed {
      logic de;
      logic hs;
      logic vs;
      logic fs;
   } tag_t;

   localparam int DEF_H_ACTIVE = 800;
   localparam int DEF_H_FP     = 40;
   localparam int DEF_H_SYNC   = 48;
   localparam int DEF_H_BP     = 40;
   localparam int DEF_V_ACTIVE = 480;
   localparam int DEF_V_FP     = 13;
   localparam int DEF_V_SYNC   = 3;
   localparam int DEF_V_BP     = 29;

   // Grey level for palette entry idx: the index bit pattern repeated to fill 8 bits.
   function automatic rgb_t grey_ramp(input int idx, input int width);
      logic [7:0] lvl;
      logic [7:0] idx_bits;
      idx_bits = 8'(idx);
      lvl      = '0;
      for (int k = 0; k < 8; k++) begin
         lvl[7-k] = idx_bits[width-1-(k%width)];
      end
      return '{r: lvl, g: lvl, b: lvl};
   endfunction

endpackage

// File: rtl/lcd_timing.sv
// Raster counters for the LCD engine: horizontal/vertical position, active
// window, raw (active-high) sync windows and the frame-origin tag.
module lcd_timing
   import lcd_pkg::*;
#(
   parameter int H_ACTIVE = DEF_H_ACTIVE,
   parameter int H_FP     = DEF_H_FP,
   parameter int H_SYNC   = DEF_H_SYNC,
   parameter int H_BP     = DEF_H_BP,
   parameter int V_ACTIVE = DEF_V_ACTIVE,
   parameter int V_FP     = DEF_V_FP,
   parameter int V_SYNC   = DEF_V_SYNC,
   parameter int V_BP     = DEF_V_BP
) (
   input  logic pixel_clock,
   input  logic pixel_reset,
   output logic active,
   output logic hsync,
   output logic vsync,
   output logic frame_tag
);

   localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
   localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
   localparam int HW      = $clog2(H_TOTAL);
   localparam int VW      = $clog2(V_TOTAL);

   logic [HW-1:0] sx_reg, sx_next;
   logic [VW-1:0] sy_reg, sy_next;

   always_ff @(posedge pixel_clock or negedge pixel_reset) begin
      if (!pixel_reset) begin
         sx_reg <= '0;
         sy_reg <= '0;
      end else begin
         sx_reg <= sx_next;
         sy_reg <= sy_next;
      end
   end

   always_comb begin
      sx_next = sx_reg + 1'b1;
      sy_next = sy_reg;
      if (32'(sx_reg) == H_TOTAL - 1) begin
         sx_next = '0;
         sy_next = (32'(sy_reg) == V_TOTAL - 1) ? '0 : sy_reg + 1'b1;
      end
   end

   // Comparisons are widened to 32 bits so a zero back porch cannot overflow the bound.
   assign active    = (32'(sx_reg) < H_ACTIVE) && (32'(sy_reg) < V_ACTIVE);
   assign hsync     = (32'(sx_reg) >= H_ACTIVE + H_FP) &&
                      (32'(sx_reg) <  H_ACTIVE + H_FP + H_SYNC);
   assign vsync     = (32'(sy_reg) >= V_ACTIVE + V_FP) &&
                      (32'(sy_reg) <  V_ACTIVE + V_FP + V_SYNC);
   assign frame_tag = (sx_reg == '0) && (sy_reg == '0);

endmodule

// File: rtl/lcd_scanout.sv
// LCD scan-out engine: fetches pixel indices from a double-buffered framebuffer,
// maps them through a writable palette and drives registered panel pins.
module lcd_scanout
   import lcd_pkg::*;
#(
   parameter int H_ACTIVE   = DEF_H_ACTIVE,
   parameter int H_FP       = DEF_H_FP,
   parameter int H_SYNC     = DEF_H_SYNC,
   parameter int H_BP       = DEF_H_BP,
   parameter int V_ACTIVE   = DEF_V_ACTIVE,
   parameter int V_FP       = DEF_V_FP,
   parameter int V_SYNC     = DEF_V_SYNC,
   parameter int V_BP       = DEF_V_BP,
   parameter bit HSYNC_POL  = 1'b0,
   parameter bit VSYNC_POL  = 1'b0,
   parameter int INDEX_W    = 4,
   parameter int RD_LATENCY = 1,
   parameter int ADDR_W     = $clog2(2*H_ACTIVE*V_ACTIVE)
) (
   input  logic               pixel_clock,
   input  logic               pixel_reset,
   input  logic               enable,
   input  logic               fb_select,
   output logic               fb_rd,
   output logic [ADDR_W-1:0]  fb_addr,
   input  logic [INDEX_W-1:0] fb_data,
   input  logic               pal_we,
   input  logic [INDEX_W-1:0] pal_addr,
   input  logic [23:0]        pal_data,
   output logic               frame_start,
   output logic               lcd_de,
   output logic               lcd_hsync,
   output logic               lcd_vsync,
   output logic [7:0]         lcd_red,
   output logic [7:0]         lcd_green,
   output logic [7:0]         lcd_blue
);

   localparam int                PAL_DEPTH = 2**INDEX_W;
   localparam logic [ADDR_W-1:0] BUF1_BASE = ADDR_W'(H_ACTIVE*V_ACTIVE);

   logic active, hsync_raw, vsync_raw, frame_tag;

   lcd_timing #(
      .H_ACTIVE (H_ACTIVE), .H_FP (H_FP), .H_SYNC (H_SYNC), .H_BP (H_BP),
      .V_ACTIVE (V_ACTIVE), .V_FP (V_FP), .V_SYNC (V_SYNC), .V_BP (V_BP)
   ) u_timing (
      .pixel_clock (pixel_clock),
      .pixel_reset (pixel_reset),
      .active      (active),
      .hsync       (hsync_raw),
      .vsync       (vsync_raw),
      .frame_tag   (frame_tag)
   );

   // ptr_reg is the address of the next active pixel; the buffer choice made at
   // the frame origin lives on in it for the rest of the frame.
   tag_t              tag_s0_reg;
   logic [ADDR_W-1:0] fb_addr_reg, ptr_reg, base_sel;

   assign base_sel = fb_select ? BUF1_BASE : '0;

   always_ff @(posedge pixel_clock or negedge pixel_reset) begin
      if (!pixel_reset) begin
         tag_s0_reg  <= '0;
         fb_addr_reg <= '0;
         ptr_reg     <= '0;
      end else begin
         tag_s0_reg <= '{de: active && enable, hs: hsync_raw, vs: vsync_raw, fs: frame_tag};
         if (frame_tag) begin
            fb_addr_reg <= base_sel;
            ptr_reg     <= base_sel + 1'b1;
         end else if (active) begin
            fb_addr_reg <= ptr_reg;
            ptr_reg     <= ptr_reg + 1'b1;
         end
      end
   end

   assign fb_rd   = tag_s0_reg.de;
   assign fb_addr = fb_addr_reg;

   tag_t pipe_reg [RD_LATENCY];
   tag_t tag_l;

   for (genvar gi = 0; gi < RD_LATENCY; gi++) begin : g_pipe
      tag_t src;
      if (gi == 0) begin : g_head
         assign src = tag_s0_reg;
      end else begin : g_tail
         assign src = pipe_reg[gi-1];
      end
      always_ff @(posedge pixel_clock or negedge pixel_reset) begin
         if (!pixel_reset) pipe_reg[gi] <= '0;
         else              pipe_reg[gi] <= src;
      end
   end

   assign tag_l = pipe_reg[RD_LATENCY-1];

   // Palette is a register file rather than RAM so reset can restore the grey ramp.
   rgb_t pal_reg [PAL_DEPTH];

   for (genvar gi = 0; gi < PAL_DEPTH; gi++) begin : g_pal
      always_ff @(posedge pixel_clock or negedge pixel_reset) begin
         if (!pixel_reset)                              pal_reg[gi] <= grey_ramp(gi, INDEX_W);
         else if (pal_we && pal_addr == INDEX_W'(gi))   pal_reg[gi] <= pal_data;
      end
   end

   rgb_t rgb_reg;
   logic de_reg, hsync_reg, vsync_reg, fs_reg;

   always_ff @(posedge pixel_clock or negedge pixel_reset) begin
      if (!pixel_reset) begin
         de_reg    <= 1'b0;
         hsync_reg <= ~HSYNC_POL;
         vsync_reg <= ~VSYNC_POL;
         fs_reg    <= 1'b0;
         rgb_reg   <= '0;
      end else begin
         de_reg    <= tag_l.de;
         hsync_reg <= tag_l.hs ~^ HSYNC_POL;
         vsync_reg <= tag_l.vs ~^ VSYNC_POL;
         fs_reg    <= tag_l.fs;
         rgb_reg   <= tag_l.de ? pal_reg[fb_data] : '0;
      end
   end

   assign lcd_de      = de_reg;
   assign lcd_hsync   = hsync_reg;
   assign lcd_vsync   = vsync_reg;
   assign frame_start = fs_reg;
   assign lcd_red     = rgb_reg.r;
   assign lcd_green   = rgb_reg.g;
   assign lcd_blue    = rgb_reg.b;

endmodule

// File: doc/lcd_scanout.md
Name: lcd_scanout

Overview:
Parametrised LCD scan-out engine; the next generation of the panel driver. Generates programmable-timing DE/HSYNC/VSYNC and fetches INDEX_W-bit pixel indices from a double-buffered framebuffer through a fixed-latency read port. Maps indices through a writable 24-bit palette and drives registered RGB pins with control signals pipeline-aligned to the pixel data. Sits between the framebuffer RAM and the panel pins in the pixel_clock domain.

Parameters:
H_ACTIVE, 800, visible pixels per line
H_FP, 40, horizontal front porch (clocks)
H_SYNC, 48, hsync width
H_BP, 40, horizontal back porch
V_ACTIVE, 480, visible lines
V_FP, 13, vertical front porch (lines)
V_SYNC, 3, vsync width
V_BP, 29, vertical back porch
HSYNC_POL, 0, hsync active level (1 = active-high)
VSYNC_POL, 0, vsync active level
INDEX_W, 4, pixel index width (1..8); palette depth 2**INDEX_W
RD_LATENCY, 1, framebuffer read latency in clocks (>=1)
ADDR_W, $clog2(2*H_ACTIVE*V_ACTIVE), framebuffer address width

Ports:
pixel_clock  in  1  pixel clock
pixel_reset  in  1  asynchronous reset, active-low
enable  in  1  1 = scan out; 0 = blank (timing keeps running)
fb_select  in  1  front buffer select, sampled at frame start
fb_rd  out  1  framebuffer read strobe
fb_addr  out  ADDR_W  framebuffer read address
fb_data  in  INDEX_W  pixel index, valid RD_LATENCY clocks after fb_rd
pal_we  in  1  palette write enable
pal_addr  in  INDEX_W  palette write index
pal_data  in  24  palette write value {R,G,B}
frame_start  out  1  one-clock pulse with first active pixel at pins
lcd_de  out  1  data enable
lcd_hsync  out  1  horizontal sync
lcd_vsync  out  1  vertical sync
lcd_red / lcd_green / lcd_blue  out  8 each  pixel colour

Behaviour:
- Reset (pixel_reset low, async): counters sx=sy=0, fb_addr=0, fb_rd=0, lcd_de=0, hsync=!HSYNC_POL, vsync=!VSYNC_POL, RGB=0, frame_start=0, pipeline flushed, latched buffer=0; palette entry i = greyscale, i bit-replicated to 8 bits on each channel (INDEX_W=4: i*17). Leaving reset mid-frame restarts at (0,0).
- Timing: sx counts 0..H_TOTAL-1 (H_TOTAL = sum of H_*); at wrap sy increments 0..V_TOTAL-1, then wraps. active = sx<H_ACTIVE && sy<V_ACTIVE. hsync asserted for sx in [H_ACTIVE+H_FP, H_ACTIVE+H_FP+H_SYNC); vsync for sy in [V_ACTIVE+V_FP, V_ACTIVE+V_FP+V_SYNC), for the whole line.
- Buffer select: fb_select latched on the cycle counters are at (0,0); mid-frame changes have no effect until the next frame. Base = 0 (buffer 0) or H_ACTIVE*V_ACTIVE (buffer 1).
- Fetch: fb_rd = active && enable; fb_addr = base + sy*H_ACTIVE + sx, produced by an incrementing address register (no multiplier). Address advances only on active pixels and reloads to base at (0,0).
- Pipeline: de/hsync/vsync/frame-start tags are delayed by RD_LATENCY stages. On the cycle fb_data is valid, the output registers sample palette[fb_data]. Pins therefore show pixel P exactly RD_LATENCY+1 clocks after fb_addr presents P.
- Blanking: lcd_de=0 forces RGB=0. With enable=0, lcd_de=0 and RGB=0, but sync timing is unchanged.
- Palette: a write is visible to lookups from the next clock. A lookup of the index written in the same cycle returns the old value.
- frame_start: pulses in the same cycle the (0,0) pixel appears on the pins, regardless of enable.

Decomposition:
- Package lcd_pkg: rgb_t (packed 24-bit {r,g,b}), default timing constants (800x480 set), grey-ramp reset function.
- Sub-module lcd_timing: parametrised counters producing sx, sy, active, hsync, vsync and frame-start tag.
- Fetch pipeline, palette and output registers remain in lcd_scanout.

Test Plan:
- Reset values: hold reset low -> all outputs at the reset values above; palette[5] reads 0x555555 once scanned.
- Timing: H_ACTIVE=8, H_FP=2, H_SYNC=3, H_BP=1, V_ACTIVE=4, V_FP=1, V_SYNC=2, V_BP=1 -> line = 14 clocks, frame = 112 clocks; hsync spans sx 10..12; vsync spans lines 5..6; 8 DE clocks per active line.
- Latency: RD_LATENCY=2, memory model returns addr[3:0] -> pixel at fb_addr=3 appears on pins 3 clocks later with lcd_de=1, RGB=0x333333.
- Palette collision: write pal[3]=0xFF0000 in the cycle index 3 is looked up -> old 0x333333 shown; next index-3 pixel shows 0xFF0000.
- Double buffer: toggle fb_select mid-frame -> fb_addr stays in buffer 0 until next (0,0), then starts at 32.
- Enable/reset: drop enable for one line -> DE/RGB 0, fb_rd 0, syncs unchanged. Assert reset mid-line -> outputs reset immediately (async); frame restarts at (0,0) after release.
